// File: rtl/audio_mixer.sv
// Stereo mixer: latches CHANNELS 8-bit sources on strobe, pans and sums them one per clock, then scales to signed 16-bit.
// Defining MIXER_DCBLOCK_EN inserts a one-clock DC-blocking filter stage (latency CHANNELS+2 instead of CHANNELS+1).
module audio_mixer #(
  parameter int CHANNELS = 4,
  parameter int SHIFT    = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  strobe,
  input  logic [CHANNELS*8-1:0] ch,
  input  logic [CHANNELS*2-1:0] pan,
  output logic [15:0]           ldata,
  output logic [15:0]           rdata,
  output logic                  valid,
  output logic                  busy
);
  localparam int AW = 8 + $clog2(CHANNELS);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, ACC, FILT, OUT} state_t;
  state_t state_q, state_d;

  logic [IW-1:0]         idx;
  logic [AW-1:0]         acc_l, acc_r;
  logic [CHANNELS*8-1:0] ch_sh;
  logic [CHANNELS*2-1:0] pan_sh;
  logic [7:0]            ch_sel;
  logic [AW-1:0]         add_l, add_r;
  logic [15:0]           conv_l, conv_r;

  // Scale, saturate anything beyond 16 unsigned bits, then flip the MSB to re-centre.
  function automatic logic [15:0] convert(input logic [AW-1:0] a);
    logic [31:0] s;
    s = 32'(a) << SHIFT;
    if (s > 32'd65535) return 16'h7FFF;
    return s[15:0] ^ 16'h8000;
  endfunction

  always_comb begin
    ch_sel = ch_sh[8*idx +: 8];
    add_l  = pan_sh[2*idx]   ? AW'(ch_sel) : '0;
    add_r  = pan_sh[2*idx+1] ? AW'(ch_sel) : '0;
    conv_l = convert(acc_l);
    conv_r = convert(acc_r);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (strobe) state_d = ACC;
      ACC: begin
        if (idx == LAST) begin
`ifdef MIXER_DCBLOCK_EN
          state_d = FILT;
`else
          state_d = OUT;
`endif
        end
      end
      FILT:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MIXER_DCBLOCK_EN
  logic signed [15:0] xp_l, xp_r, yp_l, yp_r;

  // y = x - x_prev + y_prev - y_prev/1024, evaluated at 18 bits and saturated back to 16.
  function automatic logic signed [15:0] dcblock(input logic signed [15:0] x,
                                                 input logic signed [15:0] xp,
                                                 input logic signed [15:0] yp);
    logic signed [15:0] yd;
    logic signed [17:0] y;
    yd = yp >>> 10;
    y  = {{2{x[15]}}, x} - {{2{xp[15]}}, xp} + {{2{yp[15]}}, yp} - {{2{yd[15]}}, yd};
    if (y > 18'sd32767)  return 16'sh7FFF;
    if (y < -18'sd32768) return 16'sh8000;
    return y[15:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xp_l <= '0;
      xp_r <= '0;
      yp_l <= '0;
      yp_r <= '0;
    end else if (state_q == FILT) begin
      xp_l <= conv_l;
      xp_r <= conv_r;
      yp_l <= dcblock(conv_l, xp_l, yp_l);
      yp_r <= dcblock(conv_r, xp_r, yp_r);
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx    <= '0;
      acc_l  <= '0;
      acc_r  <= '0;
      ch_sh  <= '0;
      pan_sh <= '0;
      ldata  <= '0;
      rdata  <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strobe) begin
            ch_sh  <= ch;
            pan_sh <= pan;
            acc_l  <= '0;
            acc_r  <= '0;
            idx    <= '0;
            busy   <= 1'b1;
          end
        end
        ACC: begin
          acc_l <= acc_l + add_l;
          acc_r <= acc_r + add_r;
          idx   <= idx + 1'b1;
        end
        OUT: begin
`ifdef MIXER_DCBLOCK_EN
          ldata <= yp_l;
          rdata <= yp_r;
`else
          ldata <= conv_l;
          rdata <= conv_r;
`endif
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench: two mixers (SHIFT=6 and SHIFT=7) share stimulus; expected samples come from a panned-sum model.
module tb_audio_mixer;
  localparam int CH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic strobe = 1'b0;
  logic [CH*8-1:0] ch = '0;
  logic [CH*2-1:0] pan = '0;
  logic [15:0] l6, r6, l7, r7;
  logic v6, b6, v7, b7;

  always #5 clock = ~clock;

  audio_mixer #(.CHANNELS(CH), .SHIFT(6)) dut6 (
    .clock(clock), .reset(reset), .strobe(strobe), .ch(ch), .pan(pan),
    .ldata(l6), .rdata(r6), .valid(v6), .busy(b6)
  );
  audio_mixer #(.CHANNELS(CH), .SHIFT(7)) dut7 (
    .clock(clock), .reset(reset), .strobe(strobe), .ch(ch), .pan(pan),
    .ldata(l7), .rdata(r7), .valid(v7), .busy(b7)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          at_edge;
  } exp_t;

  exp_t q6[$];
  exp_t q7[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int next_free = 0;
  logic [31:0] held6 = '0;
  logic [31:0] held7 = '0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] conv(input int v, input int sh);
    int s;
    s = v << sh;
    if (s > 65535) return 16'h7FFF;
    return 16'(s - 32768);
  endfunction

  function automatic exp_t model(input logic [CH*8-1:0] c, input logic [CH*2-1:0] p,
                                 input int sh, input int e);
    int sl, sr;
    exp_t x;
    sl = 0;
    sr = 0;
    for (int i = 0; i < CH; i++) begin
      if (p[2*i])   sl += int'(c[8*i +: 8]);
      if (p[2*i+1]) sr += int'(c[8*i +: 8]);
    end
    x.l = conv(sl, sh);
    x.r = conv(sr, sh);
    x.at_edge = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clock) begin
    logic exp_busy;
    logic exp_valid;
    exp_t e6, e7;
    if (!reset) begin
      chk("rst_data6", {l6, r6}, 32'h0);
      chk("rst_ctl6", {30'h0, v6, b6}, 32'h0);
      chk("rst_data7", {l7, r7}, 32'h0);
      chk("rst_ctl7", {30'h0, v7, b7}, 32'h0);
      held6 = '0;
      held7 = '0;
    end else begin
      while (q6.size() > 0 && q6[0].at_edge < cyc) void'(q6.pop_front());
      while (q7.size() > 0 && q7[0].at_edge < cyc) void'(q7.pop_front());
      exp_busy = 1'b0;
      foreach (q6[i])
        if (cyc >= q6[i].at_edge - CH - 1 && cyc < q6[i].at_edge) exp_busy = 1'b1;
      chk("busy6", {31'h0, b6}, {31'h0, exp_busy});
      chk("busy7", {31'h0, b7}, {31'h0, exp_busy});

      exp_valid = (q6.size() > 0) && (q6[0].at_edge == cyc);
      chk("valid6", {31'h0, v6}, {31'h0, exp_valid});
      if (v6 && q6.size() > 0) begin
        e6 = q6.pop_front();
        chk("sample6", {l6, r6}, {e6.l, e6.r});
        held6 = {e6.l, e6.r};
      end else if (!v6) begin
        chk("hold6", {l6, r6}, held6);
      end

      exp_valid = (q7.size() > 0) && (q7[0].at_edge == cyc);
      chk("valid7", {31'h0, v7}, {31'h0, exp_valid});
      if (v7 && q7.size() > 0) begin
        e7 = q7.pop_front();
        chk("sample7", {l7, r7}, {e7.l, e7.r});
        held7 = {e7.l, e7.r};
      end else if (!v7) begin
        chk("hold7", {l7, r7}, held7);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // The strobe set now is sampled at edge cyc+1; it is only accepted when the mixer is idle there.
  task automatic send(input logic [CH*8-1:0] c, input logic [CH*2-1:0] p);
    int e;
    ch = c;
    pan = p;
    strobe = 1'b1;
    e = cyc + 1;
    if (reset && e >= next_free) begin
      q6.push_back(model(c, p, 6, e + CH + 1));
      q7.push_back(model(c, p, 7, e + CH + 1));
      next_free = e + CH + 2;
    end
    tick(1);
    strobe = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b1;
    tick(4);

    send(32'hFFFF_FFFF, 8'hFF);
    tick(8);
    send(32'h0000_0000, 8'hFF);
    tick(8);
    send(32'h0000_0080, 8'h01);
    tick(8);

    send(32'h1122_3344, 8'hA5);
    tick(1);
    send(32'hDEAD_BEEF, 8'h5A);
    tick(10);

    // Strobe every cycle: only the ones landing in IDLE may start a sample.
    for (int i = 0; i < 16; i++) send($urandom, 8'($urandom));
    tick(8);

    send(32'hFFFF_FFFF, 8'hFF);
    tick(2);
    reset = 1'b0;
    q6.delete();
    q7.delete();
    next_free = 0;
    tick(3);
    reset = 1'b1;
    tick(8);

    repeat (300) begin
      int gap;
      gap = $urandom_range(0, 7);
      repeat (gap) begin
        ch = $urandom;
        pan = 8'($urandom);
        tick(1);
      end
      send($urandom, 8'($urandom));
    end
    tick(CH + 4);
    chk("drained6", q6.size(), 32'h0);
    chk("drained7", q7.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
